comp_mem_ctrl: RTL and testbench

Sequencer for the compensation-weight memory of the systolic array. In the LOAD phase it turns the compensation-weight stream (value, valid, column-change marker) into write strobes and addresses. In the READ phase it plays the stored entries back, column-major, to the PE compensation path under downstream backpressure. It owns all address generation, so the memory itself is a plain synchronous RAM.

---
 rtl/comp_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_comp_mem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_mem_ctrl.sv
// comp_mem_ctrl: sequencer for the systolic-array compensation-weight memory.
// The LOAD phase turns a (weight, valid, column-change) stream into RAM write
// strobes and addresses. The READ phase plays the stored entries back in
// column-major order, and stalls while the consumer applies backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_start, rd_start     one-cycle command pulses
//   comp_weight, comp_valid  incoming weight stream
//   change_col               closes the current column after this cycle
//   rd_ready                 downstream accepts a read this cycle
//   wr_en/wr_addr/wr_data    RAM write port (registered)
//   rd_en/rd_addr/rd_col     RAM read port and the column being read (registered)
//   rd_last                  marks the read of address ROWS*COLS-1
//   load_done                level; the memory holds a complete load
//   busy                     high in LOAD or READ
//   err_ovf                  sticky; a weight arrived outside LOAD
//
// state | meaning
// IDLE  | waiting for load_start
// LOAD  | accepting weights and issuing writes
// DONE  | memory loaded; waiting for rd_start or a new load_start
// READ  | playing back entries under rd_ready
module comp_mem_ctrl #(
  parameter int ROWS = 3,
  parameter int COLS = 8,
  parameter int W    = 3,
  parameter int AW   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [W-1:0]             comp_weight,
  input  logic                     comp_valid,
  input  logic                     change_col,
  input  logic                     rd_start,
  input  logic                     rd_ready,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [W-1:0]             wr_data,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_addr,
  output logic [$clog2(COLS)-1:0]  rd_col,
  output logic                     rd_last,
  output logic                     load_done,
  output logic                     busy,
  output logic                     err_ovf
);

  localparam int CW = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS * COLS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, READ} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [AW-1:0]   rd_cnt;
  logic [RW-1:0]   rd_row;
  logic [CW-1:0]   rd_ccol;

  logic [AW-1:0]   wr_idx;
  logic            col_end;
  logic            row_end;
  logic            rd_row_end;

  // Index built from the separate column/row counters; ROWS is constant so
  // the multiply reduces to shifts and adds.
  always_comb begin
    wr_idx     = AW'(col) * AW'(ROWS) + AW'(row);
    col_end    = (col == CW'(COLS - 1));
    row_end    = (row == RW'(ROWS - 1));
    rd_row_end = (rd_row == RW'(ROWS - 1));
  end

  assign busy = (state == LOAD) || (state == READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      rd_cnt    <= '0;
      rd_row    <= '0;
      rd_ccol   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_col    <= '0;
      rd_last   <= 1'b0;
      load_done <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      rd_last <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state   <= LOAD;
            col     <= '0;
            row     <= '0;
            err_ovf <= 1'b0;
          end else if (comp_valid) begin
            err_ovf <= 1'b1;
          end
        end
        LOAD: begin
          if (comp_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_idx;
            wr_data <= comp_weight;
          end
          // change_col closes the column whether or not a weight came with it.
          if (change_col || (comp_valid && row_end)) begin
            row <= '0;
            if (col_end) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else if (comp_valid) begin
            row <= row + 1'b1;
          end
        end
        DONE: begin
          if (load_start) begin
            state     <= LOAD;
            load_done <= 1'b0;
            col       <= '0;
            row       <= '0;
            err_ovf   <= 1'b0;
          end else begin
            if (rd_start) begin
              state   <= READ;
              rd_cnt  <= '0;
              rd_row  <= '0;
              rd_ccol <= '0;
            end
            if (comp_valid) err_ovf <= 1'b1;
          end
        end
        READ: begin
          if (comp_valid) err_ovf <= 1'b1;
          if (rd_ready) begin
            rd_en   <= 1'b1;
            rd_addr <= rd_cnt;
            rd_col  <= rd_ccol;
            rd_last <= (rd_cnt == LAST_ADDR);
            if (rd_cnt == LAST_ADDR) begin
              state <= DONE;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
              if (rd_row_end) begin
                rd_row  <= '0;
                rd_ccol <= rd_ccol + 1'b1;
              end else begin
                rd_row <= rd_row + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_mem_ctrl.sv
module tb_comp_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic [2:0] comp_weight = '0;
  logic       comp_valid = 1'b0;
  logic       change_col = 1'b0;
  logic       rd_start = 1'b0;
  logic       rd_ready = 1'b0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [2:0] wr_data;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [2:0] rd_col;
  logic       rd_last;
  logic       load_done;
  logic       busy;
  logic       err_ovf;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {logic [4:0] addr; logic [2:0] data; logic done;} wr_exp_t;
  typedef struct {logic [4:0] addr; logic [2:0] col; logic last;} rd_exp_t;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];

  comp_mem_ctrl #(.ROWS(3), .COLS(8), .W(3), .AW(5)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .comp_weight(comp_weight),
    .comp_valid(comp_valid), .change_col(change_col), .rd_start(rd_start),
    .rd_ready(rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_col(rd_col), .rd_last(rd_last),
    .load_done(load_done), .busy(busy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input int data, input bit done);
    wr_exp_t e;
    e.addr = 5'(addr);
    e.data = 3'(data);
    e.done = done;
    wr_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_addrs"}, 32'({wr_addr, wr_data, rd_addr, rd_col}), 0);
    chk({tag, "_rd_last"}, 32'(rd_last), 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err_ovf"}, 32'(err_ovf), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic full_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      comp_valid  = 1'b1;
      comp_weight = 3'(i % 8);
      push_wr(i, i % 8, i == 23);
      tick();
    end
    comp_valid = 1'b0;
    tick();
    tick();
  endtask

  // Scoreboard side: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (wr_en || rd_en) chk("wr_rd_exclusive", 32'(wr_en & rd_en), 0);
    if (wr_en) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("wr_load_done", 32'(load_done), 32'(e.done));
      end
    end
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
        chk("rd_col", 32'(rd_col), 32'(e.col));
        chk("rd_last", 32'(rd_last), 32'(e.last));
        chk("rd_load_done_held", 32'(load_done), 1);
      end
    end else if (rd_last) begin
      chk("rd_last_without_rd_en", 32'(rd_last), 0);
    end
  end

  initial begin
    int n;
    // Reset state
    do_reset();
    check_zero("reset");

    // Sequential full load: addresses 0..23, done with the last write
    full_load();
    chk("t1_load_done", 32'(load_done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_wr_drained", 32'(wr_q.size()), 0);

    // Playback with rd_ready toggling
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("t3_busy_read", 32'(busy), 1);
    n = 0;
    for (int k = 0; k < 80 && n < 24; k++) begin
      rd_ready = (k % 2 == 0);
      if (rd_ready) begin
        rd_exp_t e;
        e.addr = 5'(n);
        e.col  = 3'(n / 3);
        e.last = (n == 23);
        rd_q.push_back(e);
        n++;
      end
      tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    chk("t3_reads_issued", 32'(n), 24);
    chk("t3_rd_drained", 32'(rd_q.size()), 0);
    chk("t3_load_done", 32'(load_done), 1);
    chk("t3_busy_done", 32'(busy), 0);

    // Weight arriving in DONE is dropped and flagged
    comp_valid = 1'b1;
    comp_weight = 3'd5;
    tick();
    comp_valid = 1'b0;
    tick();
    chk("t4_err_ovf_set", 32'(err_ovf), 1);
    chk("t4_load_done", 32'(load_done), 1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("t4_err_ovf_clr", 32'(err_ovf), 0);
    chk("t4_busy_load", 32'(busy), 1);
    chk("t4_load_done_clr", 32'(load_done), 0);

    // Ten writes, then reset aborts the load
    for (int i = 0; i < 10; i++) begin
      comp_valid  = 1'b1;
      comp_weight = 3'((i * 3) % 8);
      push_wr(i, (i * 3) % 8, 1'b0);
      tick();
    end
    comp_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("t5_abort");
    chk("t5_wr_drained", 32'(wr_q.size()), 0);
    tick();

    // Column changes: early close of column 0, then an empty column 2
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    comp_valid = 1'b1;
    comp_weight = 3'd1; push_wr(0, 1, 1'b0); tick();
    change_col = 1'b1;
    comp_weight = 3'd2; push_wr(1, 2, 1'b0); tick();
    change_col = 1'b0;
    comp_weight = 3'd3; push_wr(3, 3, 1'b0); tick();
    comp_weight = 3'd4; push_wr(4, 4, 1'b0); tick();
    comp_weight = 3'd6; push_wr(5, 6, 1'b0); tick();
    comp_valid = 1'b0;
    change_col = 1'b1;
    tick();
    change_col = 1'b0;
    comp_valid = 1'b1;
    comp_weight = 3'd7; push_wr(9, 7, 1'b0); tick();
    comp_valid = 1'b0;
    tick();
    chk("t2_wr_drained", 32'(wr_q.size()), 0);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_err_ovf", 32'(err_ovf), 0);

    // load_start beats rd_start in DONE
    do_reset();
    full_load();
    chk("t6_done_before", 32'(load_done), 1);
    load_start = 1'b1;
    rd_start   = 1'b1;
    rd_ready   = 1'b1;
    tick();
    load_start = 1'b0;
    rd_start   = 1'b0;
    chk("t6_busy_load", 32'(busy), 1);
    chk("t6_load_done_clr", 32'(load_done), 0);
    tick();
    chk("t6_no_rd_en", 32'(rd_en), 0);
    tick();
    rd_ready = 1'b0;
    tick();
    chk("t6_rd_q_empty", 32'(rd_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
